// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
//   arb_state_t  : arbiter FSM states
//   RR_PTR_RESET : distance below NUM_REQ that rr_ptr resets to
//   clog2_min1   : $clog2 clamped to at least 1 bit
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    // rr_ptr resets to NUM_REQ - RR_PTR_RESET (the last requester), so the
    // upward search after reset starts at requester 0.
    localparam int RR_PTR_RESET = 1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: searches upward (wrapping) from rr_ptr+1.
//   req       in  : request vector
//   rr_ptr    in  : index of the last owner (lowest priority)
//   grant     out : one-hot winner, zero when no request
//   grant_idx out : winner index
//   any_req   out : at least one request present
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_req
);

    localparam int IDW = $clog2(NUM_REQ);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin
// arbitration, locked multi-word bursts and a watchdog timer.
//   clk, rstn                  : clock, asynchronous active-low reset
//   req_valid/last/data        : per-requester word requests (data flattened)
//   req_ready                  : one-cycle pulse, word consumed
//   rsp_valid/data/err         : one-hot response pulse, rx word, timeout flag
//   spi_start/tx_data          : master start pulse and held tx word
//   spi_busy/done/rx_data      : master status and received word
//   cs_sel                     : one-hot slave select, zero when idle
//   grant_id                   : current owner index
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int TIMEOUT_CLK_NUM = 1024
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    input  logic                          spi_busy,
    input  logic                          spi_done,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data,
    output logic [NUM_REQ-1:0]            cs_sel,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int             IDW     = clog2_min1(NUM_REQ);
    localparam int             TW      = clog2_min1(TIMEOUT_CLK_NUM + 1);
    localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT_CLK_NUM);
    localparam logic [TW-1:0]  TLAST   = TW'(TIMEOUT_CLK_NUM - 1);
    localparam logic [IDW-1:0] RR_INIT = IDW'(NUM_REQ - RR_PTR_RESET);

    arb_state_t            state_q, state_d;
    logic [IDW-1:0]        rr_q, rr_d, gid_d;
    logic                  last_q, last_d;
    logic [TW-1:0]         tmr_q, tmr_d, tmr_inc;
    logic                  tmr_exp;
    logic [NUM_REQ-1:0]    ready_d, rspv_d, cs_d, pick;
    logic [IDW-1:0]        pick_idx;
    logic                  any_req, start_d, err_d;
    logic [DATA_WIDTH-1:0] rdata_d, tx_d;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign req_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_q),
        .grant     (pick),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Saturating timer; expiry fires on the cycle it would reach TIMEOUT.
    assign tmr_inc = (tmr_q == TMAX) ? TMAX : tmr_q + 1'b1;
    assign tmr_exp = (tmr_q >= TLAST);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = grant_id;
        last_d  = last_q;
        tmr_d   = tmr_q;
        cs_d    = cs_sel;
        tx_d    = spi_tx_data;
        ready_d = '0;
        rspv_d  = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                // spi_busy covers the master's CS_N high-hold after a release.
                if (any_req && !spi_busy) begin
                    gid_d   = pick_idx;
                    cs_d    = pick;
                    tmr_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_valid[grant_id]) begin
                    tx_d             = req_words[grant_id];
                    last_d           = req_last[grant_id];
                    start_d          = 1'b1;
                    ready_d[grant_id] = 1'b1;
                    tmr_d            = '0;
                    state_d          = WAIT_DONE;
                end else if (tmr_exp) begin
                    rspv_d[grant_id] = 1'b1;
                    err_d            = 1'b1;
                    state_d          = RELEASE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            WAIT_DONE: begin
                // A done on the expiry cycle still counts as a good transfer.
                if (spi_done) begin
                    rspv_d[grant_id] = 1'b1;
                    rdata_d          = spi_rx_data;
                    if (last_q) begin
                        state_d = RELEASE;
                    end else begin
                        tmr_d   = '0;
                        state_d = ISSUE;
                    end
                end else if (tmr_exp) begin
                    rspv_d[grant_id] = 1'b1;
                    err_d            = 1'b1;
                    state_d          = RELEASE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            RELEASE: begin
                rr_d    = grant_id;
                cs_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_q        <= RR_INIT;
            last_q      <= 1'b0;
            tmr_q       <= '0;
            grant_id    <= '0;
            cs_sel      <= '0;
            spi_tx_data <= '0;
            spi_start   <= 1'b0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            last_q      <= last_d;
            tmr_q       <= tmr_d;
            grant_id    <= gid_d;
            cs_sel      <= cs_d;
            spi_tx_data <= tx_d;
            spi_start   <= start_d;
            req_ready   <= ready_d;
            rsp_valid   <= rspv_d;
            rsp_data    <= rdata_d;
            rsp_err     <= err_d;
        end
    end

endmodule
